// File: rtl/qed_pkg.sv
// Shared QED definitions: checker FSM states, default widths and the register-pair helper.
package qed_pkg;

    localparam int QED_XLEN     = 32;
    localparam int QED_NUM_REGS = 32;
    localparam int QED_CNT_W    = 16;

    typedef logic [QED_CNT_W-1:0]             qed_cnt_t;
    typedef logic [$clog2(QED_NUM_REGS)-1:0]  qed_reg_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_O,
        ST_WAIT_O,
        ST_REQ_D,
        ST_WAIT_D,
        ST_CMP,
        ST_DONE
    } qed_chk_state_e;

    // Register i is duplicated into register i + qed_half(num_regs).
    function automatic int qed_half(input int num_regs);
        return num_regs / 2;
    endfunction

endpackage

// File: rtl/qed_consistency_checker_if.sv
// Commit, check-control, register-file read and status signals of the QED consistency checker.
interface qed_consistency_checker_if
    import qed_pkg::*;
#(
    parameter int XLEN     = QED_XLEN,
    parameter int NUM_REGS = QED_NUM_REGS,
    parameter int CNT_W    = QED_CNT_W
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic             commit_valid;
    logic             commit_is_dup;
    logic             check_en;
    logic             rf_rd_req;
    logic [IDX_W-1:0] rf_rd_addr;
    logic             rf_rd_valid;
    logic [XLEN-1:0]  rf_rd_data;
    logic [CNT_W-1:0] qed_num_orig;
    logic [CNT_W-1:0] qed_num_dup;
    logic             qed_ready;
    logic             check_busy;
    logic             check_done;
    logic             check_pass;
    logic             check_abort;
    logic [IDX_W-1:0] mismatch_reg;

    modport master (
        output commit_valid, commit_is_dup, check_en, rf_rd_valid, rf_rd_data,
        input  rf_rd_req, rf_rd_addr, qed_num_orig, qed_num_dup, qed_ready,
        input  check_busy, check_done, check_pass, check_abort, mismatch_reg
    );

    modport slave (
        input  commit_valid, commit_is_dup, check_en, rf_rd_valid, rf_rd_data,
        output rf_rd_req, rf_rd_addr, qed_num_orig, qed_num_dup, qed_ready,
        output check_busy, check_done, check_pass, check_abort, mismatch_reg
    );

endinterface

// File: rtl/qed_commit_counter.sv
// Saturating commit counter; exposes the post-edge value so status can be registered in step.
module qed_commit_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic [W-1:0] value_nxt,
    output logic         sat
);
    assign sat       = &value;
    assign value_nxt = (inc && !sat) ? value + W'(1) : value;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) value <= '0;
        else         value <= value_nxt;
    end

endmodule

// File: rtl/qed_consistency_checker.sv
// Commit-side QED consistency checker: balances original/duplicate commit counts and
// compares each register pair (i, i+HALF) through the register-file read port.
module qed_consistency_checker
    import qed_pkg::*;
#(
    parameter int XLEN     = QED_XLEN,
    parameter int NUM_REGS = QED_NUM_REGS,
    parameter int CNT_W    = QED_CNT_W
) (
    input logic                      clk,
    input logic                      resetn,
    qed_consistency_checker_if.slave bus
);
    localparam int HALF  = qed_half(NUM_REGS);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] HALF_IDX  = IDX_W'(HALF);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(HALF - 1);

    logic             orig_inc, dup_inc, orig_sat, dup_sat, ready_nxt;
    logic [CNT_W-1:0] orig_cnt, dup_cnt, orig_nxt, dup_nxt;

    qed_chk_state_e   state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt, mismatch_q;
    logic [XLEN-1:0]  orig_val, dup_val;
    logic             busy, abort, rd_req, rd_dup, rd_accept, pairs_differ;
    logic             ready_q, pass_q, abort_q;

    assign orig_inc = bus.commit_valid && !bus.commit_is_dup;
    assign dup_inc  = bus.commit_valid &&  bus.commit_is_dup;

    qed_commit_counter #(.W(CNT_W)) u_orig_cnt (
        .clk(clk), .resetn(resetn), .inc(orig_inc),
        .value(orig_cnt), .value_nxt(orig_nxt), .sat(orig_sat)
    );

    qed_commit_counter #(.W(CNT_W)) u_dup_cnt (
        .clk(clk), .resetn(resetn), .inc(dup_inc),
        .value(dup_cnt), .value_nxt(dup_nxt), .sat(dup_sat)
    );

    // Built from post-edge counts so the registered flag lines up with the balancing commit.
    assign ready_nxt = (orig_nxt == dup_nxt) && (|orig_nxt) && !(&orig_nxt)
                       && !orig_sat && !dup_sat;

    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign abort        = busy && bus.commit_valid;
    assign rd_req       = state inside {ST_REQ_O, ST_WAIT_O, ST_REQ_D, ST_WAIT_D};
    assign rd_dup       = state inside {ST_REQ_D, ST_WAIT_D};
    assign rd_accept    = rd_req && bus.rf_rd_valid;
    assign pairs_differ = (orig_val != dup_val);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            ST_IDLE: begin
                if (bus.check_en && ready_q) begin
                    state_nxt = ST_REQ_O;
                    idx_nxt   = FIRST_IDX;
                end
            end
            ST_REQ_O, ST_WAIT_O: state_nxt = bus.rf_rd_valid ? ST_REQ_D : ST_WAIT_O;
            ST_REQ_D, ST_WAIT_D: state_nxt = bus.rf_rd_valid ? ST_CMP : ST_WAIT_D;
            ST_CMP: begin
                if (pairs_differ || idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_REQ_O;
                    idx_nxt   = idx + FIRST_IDX;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // A retiring instruction invalidates the snapshot being compared.
        if (abort) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rd_accept && !rd_dup) orig_val <= bus.rf_rd_data;
        if (rd_accept &&  rd_dup) dup_val  <= bus.rf_rd_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            idx        <= '0;
            ready_q    <= 1'b0;
            pass_q     <= 1'b0;
            abort_q    <= 1'b0;
            mismatch_q <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            ready_q <= ready_nxt;
            abort_q <= abort;
            if (state == ST_CMP && !abort) begin
                if (pairs_differ) begin
                    pass_q     <= 1'b0;
                    mismatch_q <= idx;
                end else if (idx == LAST_IDX) begin
                    pass_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rf_rd_req    = rd_req;
    assign bus.rf_rd_addr   = rd_dup ? idx + HALF_IDX : idx;
    assign bus.qed_num_orig = orig_cnt;
    assign bus.qed_num_dup  = dup_cnt;
    assign bus.qed_ready    = ready_q;
    assign bus.check_busy   = busy;
    assign bus.check_done   = (state == ST_DONE);
    assign bus.check_pass   = pass_q;
    assign bus.check_abort  = abort_q;
    assign bus.mismatch_reg = mismatch_q;

endmodule
